sin_src_mc: RTL and testbench
=============================

SIN_SRC_MC -- requirements
Module: sin_src_mc

Interface
REQ-001 The block SHALL have parameter NCH, default 4, number of independent sine channels (1..16).
REQ-002 The block SHALL have parameter PHASE_W, default 24, phase-accumulator width in bits.
REQ-003 The block SHALL have parameter QW, default 12, quantised output width, used only under SIN_SRC_MC_QUANT_EN.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port list, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  NCH  per-channel run enable.
- sync  in  1  restart all phase accumulators.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accept.
- cfg_ch  in  $clog2(NCH) (min 1)  target channel.
- cfg_fcw  in  PHASE_W  frequency control word.
- cfg_phase  in  PHASE_W  phase offset.
- cfg_amp  in  real  amplitude, volts.
- out  out  real[NCH]  sine sample per channel.
- out_valid  out  NCH  sample-valid per channel.
- q_out  out  signed QW [NCH]  quantised sample; present only under SIN_SRC_MC_QUANT_EN.

Function
REQ-006 Each cycle with en[c]=1, acc[c] SHALL update to (acc[c]+fcw[c]) mod 2^PHASE_W; with en[c]=0, acc[c] holds.
REQ-007 out[c] SHALL be registered as amp[c]*sin(2*pi*((acc[c]+phase[c]) mod 2^PHASE_W)/2^PHASE_W), using the pre-update acc[c], giving 1-cycle latency.
REQ-008 out_valid[c] SHALL equal en[c] delayed by one cycle; out[c] holds its last value while out_valid[c]=0.
REQ-009 The config FSM SHALL have states IDLE (cfg_ready=1) and COMMIT (cfg_ready=0).
REQ-010 IDLE->COMMIT SHALL occur on cfg_valid&&cfg_ready, capturing cfg_ch/fcw/phase/amp into shadow registers; COMMIT->IDLE SHALL occur unconditionally after one cycle, writing the shadow into the target channel.
REQ-011 Committed fcw/phase/amp SHALL first affect acc and out in the cycle after COMMIT; throughput is one config per 2 cycles.
REQ-012 A config with cfg_ch>=NCH SHALL be accepted and discarded, with no channel state changed.
REQ-013 sync=1 SHALL set every acc[c] to 0 at that edge, regardless of en; sync coincident with a COMMIT SHALL apply both (new settings, cleared acc).
REQ-014 Negative cfg_amp SHALL be legal and SHALL produce an inverted sine.

Reset
REQ-015 While rst=1, acc, fcw and phase SHALL be 0; amp and out SHALL be 0.0; out_valid and q_out SHALL be 0; FSM SHALL be IDLE; cfg_ready SHALL be 0.
REQ-016 cfg_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-017 rst asserted during COMMIT SHALL discard the pending config.

Configuration
REQ-018 When SIN_SRC_MC_QUANT_EN is defined, q_out[c] SHALL be round(out_value*(2^(QW-1)-1)), saturated to ±(2^(QW-1)-1), and registered in the same cycle as out[c].
REQ-019 When SIN_SRC_MC_QUANT_EN is undefined, q_out and all quantiser logic SHALL be absent; all other behaviour is identical.

Structure
REQ-020 Package sin_src_pkg SHALL hold the FSM state enum, the TWO_PI real constant and the quantise/saturate function.
REQ-021 Sub-module sin_src_ch SHALL implement one channel (acc, phase add, sine, output register) and SHALL be generated NCH times.

Verification
REQ-022 rst held 3 cycles -> all out 0.0, out_valid 0, cfg_ready 0 during reset and 1 on the next cycle.
REQ-023 NCH=4, PHASE_W=24; ch0 fcw=2^20, amp=1.0, phase=0, en=1 -> period 16 cycles, sample k = sin(2*pi*k/16) ±1e-9, sample 4 = 1.0.
REQ-024 Same as REQ-023, plus ch1 phase=2^22 -> out[1] = cos of ch0 angle, out[1]=1.0 on ch0's first valid sample.
REQ-025 fcw=2^24-1 -> acc wraps downward and output equals -sin(2*pi*k/2^24).
REQ-026 Back-to-back cfg_valid -> cfg_ready low exactly 1 cycle after each accept; cfg_ch=5 with NCH=4 -> no change; sync mid-run -> all channels restart at their phase offsets.
REQ-027 With SIN_SRC_MC_QUANT_EN, QW=12: amp=1.0 -> q_out peak 2047; amp=1.5 -> saturates at +2047/-2047.

Source files
------------

// File: rtl/sin_src_mc_pkg.sv
// sin_src_pkg -- shared definitions for the multi-channel sine source.
//
// Contents:
//   cfg_state_e : configuration FSM states (IDLE accepts, COMMIT writes)
//   TWO_PI      : 2*pi as a real constant used by the sine evaluation
//   ch_w()      : width of a channel index for a given channel count (min 1)
//   quant_sat() : round-half-away-from-zero quantiser with symmetric
//                 saturation to +/-(2^(qw-1)-1)
package sin_src_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } cfg_state_e;

  localparam real TWO_PI = 6.283185307179586;

  // A single-channel build still carries a 1-bit channel select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scale a sample by the full-scale code, round half away from zero and
  // clamp symmetrically so that the most negative code is never produced.
  // The clamp is done in the real domain first so large amplitudes cannot
  // overflow the integer conversion.
  function automatic int quant_sat(input real v, input int qw);
    int  lim;
    real x;
    int  r;
    lim = (1 << (qw - 1)) - 1;
    x   = v * real'(lim);
    if (x >= real'(lim)) begin
      r = lim;
    end else if (x <= -real'(lim)) begin
      r = -lim;
    end else if (x >= 0.0) begin
      r = $rtoi(x + 0.5);
    end else begin
      r = -$rtoi(-x + 0.5);
    end
    return r;
  endfunction

endpackage

// File: rtl/sin_src_mc_ch.sv
// sin_src_ch -- one sine channel of the multi-channel source.
//
// Holds the phase accumulator and the channel's committed settings
// (frequency word, phase offset, amplitude) and registers one sample per
// enabled cycle. The sample is taken from the accumulator value *before*
// this cycle's increment, so out lags the accumulator by one cycle.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en                : run enable; advances acc and produces a sample
//   sync              : clear acc at this edge (wins over the increment)
//   wr                : load wr_fcw / wr_phase / wr_amp at this edge
//   out, out_valid    : registered sample and its valid flag (en delayed)
//   q_out             : quantised sample (only with SIN_SRC_MC_QUANT_EN)
//
// Optional feature macro: SIN_SRC_MC_QUANT_EN
module sin_src_ch
  import sin_src_pkg::*;
#(
  parameter int PHASE_W = 24
`ifdef SIN_SRC_MC_QUANT_EN
  ,
  parameter int QW      = 12
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync,
  input  logic               wr,
  input  logic [PHASE_W-1:0] wr_fcw,
  input  logic [PHASE_W-1:0] wr_phase,
  input  real                wr_amp,
  output real                out,
  output logic               out_valid
`ifdef SIN_SRC_MC_QUANT_EN
  ,
  output logic signed [QW-1:0] q_out
`endif
);

  localparam real PHASE_SCALE = 2.0 ** PHASE_W;

  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] fcw;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] angle;
  real                amp;
  real                sample;

  // Modulo-2^PHASE_W addition falls out of the vector width.
  assign angle = acc + phase;

  always_comb begin
    sample = amp * $sin(TWO_PI * real'(angle) / PHASE_SCALE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      fcw       <= '0;
      phase     <= '0;
      amp       <= 0.0;
      out       <= 0.0;
      out_valid <= 1'b0;
`ifdef SIN_SRC_MC_QUANT_EN
      q_out     <= '0;
`endif
    end else begin
      out_valid <= en;
      // out (and q_out) hold their last value while the channel is idle.
      if (en) begin
        out   <= sample;
`ifdef SIN_SRC_MC_QUANT_EN
        q_out <= QW'(quant_sat(sample, QW));
`endif
      end
      // sync restarts the channel at its phase offset regardless of en.
      if (sync) begin
        acc <= '0;
      end else if (en) begin
        acc <= acc + fcw;
      end
      // New settings take effect from the next cycle on; the sample and
      // increment computed at this edge still use the old ones.
      if (wr) begin
        fcw   <= wr_fcw;
        phase <= wr_phase;
        amp   <= wr_amp;
      end
    end
  end

endmodule

// File: rtl/sin_src_mc.sv
// sin_src_mc -- NCH independent real-valued sine sources with a shared
// configuration port.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   en[NCH]          : per-channel run enable
//   sync             : restart every phase accumulator
//   cfg_valid/ready  : configuration handshake (see below)
//   cfg_ch           : target channel; values >= NCH are accepted and dropped
//   cfg_fcw          : frequency control word
//   cfg_phase        : phase offset
//   cfg_amp          : amplitude in volts (negative inverts the sine)
//   out[NCH]         : registered sine sample per channel
//   out_valid[NCH]   : en delayed by one cycle
//   q_out[NCH]       : quantised samples, only with SIN_SRC_MC_QUANT_EN
//
// Optional feature macro: SIN_SRC_MC_QUANT_EN (adds q_out and quantisers).
//
// Configuration handshake: a request transfers on a rising edge where
// cfg_valid and cfg_ready are both 1; the request fields are sampled only
// on that edge. cfg_ready never depends on cfg_valid. After a transfer the
// port is busy for exactly one cycle (COMMIT, cfg_ready=0) while the shadow
// is written into the channel, giving one accepted request per two cycles.
// cfg_ready is forced low while rst is high.
module sin_src_mc
  import sin_src_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int PHASE_W = 24,
  parameter int QW      = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic                 sync,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ch_w(NCH)-1:0] cfg_ch,
  input  logic [PHASE_W-1:0]   cfg_fcw,
  input  logic [PHASE_W-1:0]   cfg_phase,
  input  real                  cfg_amp,
  output real                  out [NCH],
  output logic [NCH-1:0]       out_valid
`ifdef SIN_SRC_MC_QUANT_EN
  ,
  output logic signed [QW-1:0] q_out [NCH]
`endif
);

  localparam int CHW = ch_w(NCH);

  // Elaboration-time guard on the supported configuration range.
  if (NCH < 1 || NCH > 16 || PHASE_W < 2 || QW < 2 || QW > 31) begin : g_param_check
    $error("sin_src_mc: unsupported parameter set");
  end

  // Configuration FSM state; kept as a named signal so checkers can bind.
  cfg_state_e         cfg_state;
  logic               ready_q;
  logic [CHW-1:0]     sh_ch;
  logic [PHASE_W-1:0] sh_fcw;
  logic [PHASE_W-1:0] sh_phase;
  real                sh_amp;
  logic               commit_wr;

  assign cfg_ready = ready_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      // A request captured just before reset is simply forgotten here.
      cfg_state <= ST_IDLE;
      ready_q   <= 1'b1;
      sh_ch     <= '0;
      sh_fcw    <= '0;
      sh_phase  <= '0;
      sh_amp    <= 0.0;
    end else begin
      case (cfg_state)
        ST_IDLE: begin
          if (cfg_valid && cfg_ready) begin
            sh_ch     <= cfg_ch;
            sh_fcw    <= cfg_fcw;
            sh_phase  <= cfg_phase;
            sh_amp    <= cfg_amp;
            cfg_state <= ST_COMMIT;
            ready_q   <= 1'b0;
          end else begin
            ready_q   <= 1'b1;
          end
        end
        ST_COMMIT: begin
          cfg_state <= ST_IDLE;
          ready_q   <= 1'b1;
        end
        default: begin
          cfg_state <= ST_IDLE;
          ready_q   <= 1'b1;
        end
      endcase
    end
  end

  // Out-of-range targets are still accepted by the FSM; no channel matches.
  assign commit_wr = (cfg_state == ST_COMMIT) && (int'(sh_ch) < NCH);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic wr;
    assign wr = commit_wr && (int'(sh_ch) == c);

    sin_src_ch #(
      .PHASE_W (PHASE_W)
`ifdef SIN_SRC_MC_QUANT_EN
      ,
      .QW      (QW)
`endif
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (en[c]),
      .sync      (sync),
      .wr        (wr),
      .wr_fcw    (sh_fcw),
      .wr_phase  (sh_phase),
      .wr_amp    (sh_amp),
      .out       (out[c]),
      .out_valid (out_valid[c])
`ifdef SIN_SRC_MC_QUANT_EN
      ,
      .q_out     (q_out[c])
`endif
    );
  end

endmodule

// File: tb/tb_sin_src_mc.sv
// tb_sin_src_mc -- self-checking bench for sin_src_mc.
//
// A four-channel instance carries the main checks; a three-channel instance
// shares the same stimulus so that cfg_ch=3 is an out-of-range target there.
// Expected values come from a reference model that evaluates the sine
// formula directly on integer accumulators, plus a table of known samples.
module tb_sin_src_mc;

  localparam int    NCH  = 4;
  localparam int    PW   = 24;
  localparam int    QW   = 12;
  localparam longint PMOD = longint'(1) << PW;
  localparam real   PI2  = 2.0 * 3.141592653589793;
  localparam real   TOL  = 1e-9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NCH-1:0]  en;
  logic            sync;
  logic            cfg_valid;
  logic            cfg_ready;
  logic            cfg_ready3;
  logic [1:0]      cfg_ch;
  logic [PW-1:0]   cfg_fcw;
  logic [PW-1:0]   cfg_phase;
  real             cfg_amp;
  real             out4 [NCH];
  real             out3 [3];
  logic [NCH-1:0]  ov4;
  logic [2:0]      ov3;
`ifdef SIN_SRC_MC_QUANT_EN
  logic signed [QW-1:0] q4 [NCH];
  logic signed [QW-1:0] q3 [3];
`endif

  sin_src_mc #(.NCH(NCH), .PHASE_W(PW), .QW(QW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_fcw   (cfg_fcw),
    .cfg_phase (cfg_phase),
    .cfg_amp   (cfg_amp),
    .out       (out4),
    .out_valid (ov4)
`ifdef SIN_SRC_MC_QUANT_EN
    ,
    .q_out     (q4)
`endif
  );

  sin_src_mc #(.NCH(3), .PHASE_W(PW), .QW(QW)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .en        (en[2:0]),
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready3),
    .cfg_ch    (cfg_ch),
    .cfg_fcw   (cfg_fcw),
    .cfg_phase (cfg_phase),
    .cfg_amp   (cfg_amp),
    .out       (out3),
    .out_valid (ov3)
`ifdef SIN_SRC_MC_QUANT_EN
    ,
    .q_out     (q3)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  function automatic real rabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_real(input string nm, input real act, input real exp);
    n_cmp++;
    if (rabs(act - exp) > TOL) begin
      n_bad++;
      $display("FAIL %s: got %.12f expected %.12f", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_acc [NCH];
  longint m_fcw [NCH];
  longint m_ph  [NCH];
  real    m_amp [NCH];
  real    m_out [NCH];
  bit     m_v   [NCH];
  bit     m_busy;
  int     p_ch;
  longint p_f, p_p;
  real    p_a;

  function automatic real ref_sample(input real a, input longint acc, input longint ph);
    return a * $sin(PI2 * real'((acc + ph) % PMOD) / real'(PMOD));
  endfunction

`ifdef SIN_SRC_MC_QUANT_EN
  function automatic int ref_q(input real v);
    real qmax;
    real x;
    qmax = real'((1 << (QW - 1)) - 1);
    x = v * qmax;
    if (x > qmax)  return int'(qmax);
    if (x < -qmax) return -int'(qmax);
    return (x >= 0.0) ? int'($floor(x + 0.5)) : -int'($floor(-x + 0.5));
  endfunction
`endif

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = 0; m_fcw[c] = 0; m_ph[c] = 0;
        m_amp[c] = 0.0; m_out[c] = 0.0; m_v[c] = 0;
      end
      m_busy = 0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (en[c]) begin
          m_out[c] = ref_sample(m_amp[c], m_acc[c], m_ph[c]);
          m_acc[c] = (m_acc[c] + m_fcw[c]) % PMOD;
        end
        m_v[c] = en[c];
        if (sync) m_acc[c] = 0;
      end
      if (m_busy) begin
        if (p_ch < NCH) begin
          m_fcw[p_ch] = p_f; m_ph[p_ch] = p_p; m_amp[p_ch] = p_a;
        end
        m_busy = 0;
      end else if (cfg_valid) begin
        p_ch = int'(cfg_ch); p_f = longint'(cfg_fcw);
        p_p = longint'(cfg_phase); p_a = cfg_amp;
        m_busy = 1;
      end
    end
  endtask

  task automatic check_all();
    logic exp_ready;
    exp_ready = !rst && !m_busy;
    chk_bit("cfg_ready", cfg_ready, exp_ready);
    chk_bit("cfg_ready3", cfg_ready3, exp_ready);
    for (int c = 0; c < NCH; c++) begin
      chk_bit($sformatf("ov4[%0d]", c), ov4[c], m_v[c]);
      chk_real($sformatf("out4[%0d]", c), out4[c], m_out[c]);
`ifdef SIN_SRC_MC_QUANT_EN
      chk_int($sformatf("q4[%0d]", c), int'(q4[c]), ref_q(m_out[c]));
`endif
    end
    for (int c = 0; c < 3; c++) begin
      chk_bit($sformatf("ov3[%0d]", c), ov3[c], m_v[c]);
      chk_real($sformatf("out3[%0d]", c), out3[c], m_out[c]);
`ifdef SIN_SRC_MC_QUANT_EN
      chk_int($sformatf("q3[%0d]", c), int'(q3[c]), ref_q(m_out[c]));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // ---------------- driver tasks ----------------
  // Present a request and hold it until accepted; reports cycles waited.
  task automatic do_cfg(input logic [1:0] ch, input logic [PW-1:0] f,
                        input logic [PW-1:0] p, input real a, output int waited);
    int n;
    n = 0;
    cfg_valid = 1'b1; cfg_ch = ch; cfg_fcw = f; cfg_phase = p; cfg_amp = a;
    while (!cfg_ready && n < 8) begin
      step();
      n++;
    end
    waited = n;
    if (n >= 8) begin
      n_cmp++; n_bad++;
      $display("FAIL cfg_timeout: cfg_ready low for %0d cycles, expected rise within 8", n);
    end else begin
      step();
      chk_bit("ready_low_after_accept", cfg_ready, 1'b0);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [NCH-1:0] en;
    real            exp0;
    real            exp1;
    real            exp3;
  } vec_t;

  vec_t tab [16];

  initial begin
    real sv [16];
    int  w;
    real hold_val;
`ifdef SIN_SRC_MC_QUANT_EN
    int qmax0, qmin0, qmax1;
`endif

    sv = '{0.0, 0.3826834323650898, 0.7071067811865476, 0.9238795325112867,
           1.0, 0.9238795325112867, 0.7071067811865476, 0.3826834323650898,
           0.0, -0.3826834323650898, -0.7071067811865476, -0.9238795325112867,
           -1.0, -0.9238795325112867, -0.7071067811865476, -0.3826834323650898};
    for (int k = 0; k < 16; k++) begin
      tab[k].en   = 4'hf;
      tab[k].exp0 = sv[k];
      tab[k].exp1 = sv[(k + 4) % 16];
      tab[k].exp3 = -sv[k];
    end

    // Reset held three cycles.
    rst = 1'b1; en = '0; sync = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_fcw = '0; cfg_phase = '0; cfg_amp = 0.0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_real("rst_out0", out4[0], 0.0);
      chk_bit("rst_out_valid", |ov4, 1'b0);
      chk_bit("rst_cfg_ready", cfg_ready, 1'b0);
    end
    rst = 1'b0;
    #1;
    chk_bit("ready_after_rst", cfg_ready, 1'b1);

    // Back-to-back configuration of all four channels.
    do_cfg(2'd0, 24'h100000, 24'h000000, 1.0, w);
    chk_int("first_cfg_wait", w, 0);
    do_cfg(2'd1, 24'h100000, 24'h400000, 1.0, w);
    chk_int("b2b_wait_ch1", w, 1);
    do_cfg(2'd2, 24'hffffff, 24'h000000, 1.0, w);
    chk_int("b2b_wait_ch2", w, 1);
    do_cfg(2'd3, 24'h100000, 24'h000000, -1.0, w);
    chk_int("b2b_wait_ch3", w, 1);
    cfg_valid = 1'b0;

    // Sync on the COMMIT edge: settings land and accumulators clear.
    sync = 1'b1;
    step();
    sync = 1'b0;

    // One full period of known samples.
    for (int k = 0; k < 16; k++) begin
      en = tab[k].en;
      step();
      chk_real($sformatf("tab_ch0_k%0d", k), out4[0], tab[k].exp0);
      chk_real($sformatf("tab_ch1_k%0d", k), out4[1], tab[k].exp1);
      chk_real($sformatf("tab_ch3_k%0d", k), out4[3], tab[k].exp3);
      chk_real($sformatf("wrap_ch2_k%0d", k), out4[2],
               -$sin(PI2 * real'(k) / 16777216.0));
    end
    step();
    chk_real("period_ch0", out4[0], 0.0);
    chk_real("period_ch1", out4[1], 1.0);

    // Output holds while disabled.
    step(); step();
    hold_val = tab[2].exp0;
    en = '0;
    step(); step();
    chk_bit("hold_valid_low", ov4[0], 1'b0);
    chk_real("hold_ch0", out4[0], hold_val);

    // Sync mid-run: every channel restarts at its phase offset.
    en = 4'hf;
    step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    step();
    chk_real("sync_ch0", out4[0], 0.0);
    chk_real("sync_ch1", out4[1], 1.0);
    chk_real("sync_ch2", out4[2], 0.0);

`ifdef SIN_SRC_MC_QUANT_EN
    // Quantiser peak and saturation.
    do_cfg(2'd0, 24'h100000, 24'h000000, 1.5, w);
    cfg_valid = 1'b0;
    sync = 1'b1;
    step();
    sync = 1'b0;
    qmax0 = -99999; qmin0 = 99999; qmax1 = -99999;
    for (int k = 0; k < 16; k++) begin
      step();
      if (int'(q4[0]) > qmax0) qmax0 = int'(q4[0]);
      if (int'(q4[0]) < qmin0) qmin0 = int'(q4[0]);
      if (int'(q4[1]) > qmax1) qmax1 = int'(q4[1]);
    end
    chk_int("q_sat_pos", qmax0, 2047);
    chk_int("q_sat_neg", qmin0, -2047);
    chk_int("q_peak_amp1", qmax1, 2047);
`endif

    // Reset during COMMIT drops the pending request.
    do_cfg(2'd0, 24'h123456, 24'h000456, 0.7, w);
    cfg_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    en = 4'hf;
    for (int i = 0; i < 3; i++) step();
    chk_real("rst_commit_out0", out4[0], 0.0);
    chk_bit("rst_commit_ready", cfg_ready, 1'b1);

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      en        = NCH'($urandom);
      sync      = ($urandom_range(0, 19) == 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_fcw   = PW'($urandom);
      cfg_phase = PW'($urandom);
      cfg_amp   = real'($urandom_range(0, 3000)) / 1000.0 - 1.5;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
